// File: rtl/out_reg_bank_ctrl.sv
// Sequencer for a bank of OUT_REG cells: drives per-lane bypass select and register clear,
// preloading lanes with live data before they leave bypass so the mode change is glitch-free.
module out_reg_bank_ctrl #(
  parameter int unsigned N_LANES        = 8,
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned PRELOAD_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [N_LANES-1:0] cfg_mask,
  input  logic [N_LANES-1:0] cfg_mode,
  input  logic               cfg_clear,
  output logic [N_LANES-1:0] sel_o,
  output logic [N_LANES-1:0] reg_rst_o,
  output logic               busy,
  output logic               done
);

  localparam int unsigned MaxCycles = (RST_CYCLES > PRELOAD_CYCLES) ? RST_CYCLES : PRELOAD_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] RstLast = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] PreLast = CntW'(PRELOAD_CYCLES - 1);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StAccept,
    StClear,
    StPreload,
    StSwitch
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N_LANES-1:0]  mask_q, mode_q, to_reg_q;
  logic                clear_q;
  logic [N_LANES-1:0]  sel_q, sel_d;
  logic [N_LANES-1:0]  reg_rst_q, reg_rst_d;
  logic                done_q, done_d;
  logic                hs;

  assign hs = cfg_valid && (state_q == StIdle);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter restarts from zero on every state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    unique case (state_q)
      StInit: begin
        if (cnt_q == RstLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (hs && (cfg_mask != '0)) state_d = StAccept;
      end
      StAccept: begin
        cnt_d = '0;
        if (clear_q)              state_d = StClear;
        else if (to_reg_q != '0)  state_d = StPreload;
        else                      state_d = StSwitch;
      end
      StClear: begin
        if (cnt_q == RstLast) begin
          cnt_d   = '0;
          state_d = (to_reg_q != '0) ? StPreload : StSwitch;
        end
      end
      StPreload: begin
        if (cnt_q == PreLast) begin
          cnt_d   = '0;
          state_d = StSwitch;
        end
      end
      StSwitch: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StInit;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    sel_d     = sel_q;
    reg_rst_d = reg_rst_q;
    done_d    = 1'b0;
    unique case (state_q)
      StInit: begin
        reg_rst_d = (cnt_q == RstLast) ? '0 : '1;
      end
      StIdle: begin
        if (hs && (cfg_mask == '0)) done_d = 1'b1;
      end
      StAccept: begin
        if (clear_q) reg_rst_d = mask_q;
      end
      StClear: begin
        if (cnt_q == RstLast) reg_rst_d = '0;
      end
      StPreload: begin
        reg_rst_d = '0;
      end
      StSwitch: begin
        sel_d  = (sel_q & ~mask_q) | (mode_q & mask_q);
        done_d = 1'b1;
      end
      default: begin
        reg_rst_d = '1;
      end
    endcase
  end

  // Output and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '1;
      reg_rst_q <= '1;
      done_q    <= 1'b0;
      mask_q    <= '0;
      mode_q    <= '0;
      clear_q   <= 1'b0;
      to_reg_q  <= '0;
    end else begin
      sel_q     <= sel_d;
      reg_rst_q <= reg_rst_d;
      done_q    <= done_d;
      if (hs) begin
        mask_q   <= cfg_mask;
        mode_q   <= cfg_mode;
        clear_q  <= cfg_clear;
        // Lanes leaving bypass need a preload of live data first
        to_reg_q <= cfg_mask & ~cfg_mode & sel_q;
      end
    end
  end

  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign sel_o     = sel_q;
  assign reg_rst_o = reg_rst_q;
  assign done      = done_q;

endmodule

// File: tb/tb_out_reg_bank_ctrl.sv
// Bench for out_reg_bank_ctrl: directed vector table, random requests against a
// transaction-level latency/select model, back-to-back and mid-operation reset sequences.
module tb_out_reg_bank_ctrl;

  localparam int unsigned N   = 8;
  localparam int unsigned RST = 2;
  localparam int unsigned PRE = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [N-1:0] cfg_mask;
  logic [N-1:0] cfg_mode;
  logic         cfg_clear;
  logic [N-1:0] sel_o;
  logic [N-1:0] reg_rst_o;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;
  logic [N-1:0] model_sel;

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] mode;
    logic         clear;
    logic [N-1:0] exp_sel;
    int           exp_lat;
  } vec_t;

  vec_t vecs [7];

  out_reg_bank_ctrl #(
    .N_LANES        (N),
    .RST_CYCLES     (RST),
    .PRELOAD_CYCLES (PRE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mask  (cfg_mask),
    .cfg_mode  (cfg_mode),
    .cfg_clear (cfg_clear),
    .sel_o     (sel_o),
    .reg_rst_o (reg_rst_o),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One request; k counts edges after the handshake edge, sampled 1 time unit later.
  task automatic run_req(input logic [N-1:0] mask, input logic [N-1:0] mode, input logic clear,
                         input logic [N-1:0] exp_sel, input int exp_lat);
    int waited = 0;
    logic [N-1:0] old_sel = model_sel;
    while (cfg_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (cfg_ready !== 1'b1) begin
      check("ready_timeout", 32'(cfg_ready), 32'd1);
      return;
    end
    cfg_valid = 1'b1;
    cfg_mask  = mask;
    cfg_mode  = mode;
    cfg_clear = clear;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int k = 0; k <= exp_lat + 1; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      check($sformatf("sel m=%h k=%0d", mask, k), 32'(sel_o),
            32'((k >= exp_lat) ? exp_sel : old_sel));
      check($sformatf("reg_rst m=%h k=%0d", mask, k), 32'(reg_rst_o),
            32'((clear && mask != '0 && k >= 1 && k <= RST) ? mask : '0));
      check($sformatf("done m=%h k=%0d", mask, k), 32'(done), 32'(k == exp_lat));
      check($sformatf("busy m=%h k=%0d", mask, k), 32'(busy),
            32'(mask != '0 && k < exp_lat));
    end
    model_sel = exp_sel;
  endtask

  initial begin
    vecs[0] = '{mask: 8'h01, mode: 8'h00, clear: 1'b0, exp_sel: 8'hFE, exp_lat: 3};
    vecs[1] = '{mask: 8'h0F, mode: 8'h0F, clear: 1'b1, exp_sel: 8'hFF, exp_lat: 4};
    vecs[2] = '{mask: 8'h00, mode: 8'h00, clear: 1'b0, exp_sel: 8'hFF, exp_lat: 0};
    vecs[3] = '{mask: 8'hF0, mode: 8'h00, clear: 1'b0, exp_sel: 8'h0F, exp_lat: 3};
    vecs[4] = '{mask: 8'h30, mode: 8'h10, clear: 1'b1, exp_sel: 8'h1F, exp_lat: 4};
    vecs[5] = '{mask: 8'h03, mode: 8'h03, clear: 1'b0, exp_sel: 8'h1F, exp_lat: 2};
    vecs[6] = '{mask: 8'h81, mode: 8'h00, clear: 1'b1, exp_sel: 8'h1E, exp_lat: 5};

    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_mask  = '0;
    cfg_mode  = '0;
    cfg_clear = 1'b0;
    model_sel = '1;

    // Reset values and release timing
    repeat (2) @(posedge clk);
    #1;
    check("rst sel", 32'(sel_o), 32'hFF);
    check("rst reg_rst", 32'(reg_rst_o), 32'hFF);
    check("rst ready", 32'(cfg_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd1);
    check("rst done", 32'(done), 32'd0);
    rst_n = 1'b1;
    #1;
    check("init c1 reg_rst", 32'(reg_rst_o), 32'hFF);
    check("init c1 ready", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    check("init c2 reg_rst", 32'(reg_rst_o), 32'hFF);
    check("init c2 ready", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    check("init c3 reg_rst", 32'(reg_rst_o), 32'h00);
    check("init c3 ready", 32'(cfg_ready), 32'd1);
    check("init c3 busy", 32'(busy), 32'd0);
    check("init c3 sel", 32'(sel_o), 32'hFF);

    foreach (vecs[i]) begin
      run_req(vecs[i].mask, vecs[i].mode, vecs[i].clear, vecs[i].exp_sel, vecs[i].exp_lat);
    end

    // Random requests against the transaction-level model
    for (int r = 0; r < 40; r++) begin
      logic [N-1:0] m, md, to_reg, nsel;
      logic         c;
      int           lat;
      m  = N'($urandom);
      if ($urandom_range(0, 4) == 0) m = '0;
      md = N'($urandom);
      c  = 1'($urandom_range(0, 1));
      to_reg = m & ~md & model_sel;
      if (m == '0) begin
        lat  = 0;
        nsel = model_sel;
      end else begin
        lat  = 2 + (c ? RST : 0) + ((to_reg != '0) ? PRE : 0);
        nsel = (model_sel & ~m) | (md & m);
      end
      run_req(m, md, c, nsel, lat);
    end

    // Back-to-back with cfg_valid held: every handshake yields exactly one done
    begin
      int hs_cnt = 0;
      int done_cnt = 0;
      logic pend;
      cfg_valid = 1'b1;
      cfg_mask  = 8'h0C;
      cfg_mode  = 8'h0C;
      cfg_clear = 1'b0;
      for (int c = 0; c < 30; c++) begin
        pend = cfg_valid && cfg_ready;
        @(posedge clk); #1;
        if (pend) hs_cnt++;
        if (done) done_cnt++;
      end
      cfg_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        if (done) done_cnt++;
      end
      model_sel = model_sel | 8'h0C;
      check("b2b done==hs", 32'(done_cnt), 32'(hs_cnt));
      check("b2b hs count", 32'(hs_cnt), 32'd10);
      check("b2b sel", 32'(sel_o), 32'(model_sel));
    end

    // Reset asserted while in CLEAR
    begin
      int done_cnt = 0;
      cfg_valid = 1'b1;
      cfg_mask  = 8'h0F;
      cfg_mode  = 8'h0F;
      cfg_clear = 1'b1;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      @(posedge clk); #1;
      check("midrst clear reg_rst", 32'(reg_rst_o), 32'h0F);
      rst_n = 1'b0;
      #1;
      check("midrst reg_rst", 32'(reg_rst_o), 32'hFF);
      check("midrst sel", 32'(sel_o), 32'hFF);
      check("midrst ready", 32'(cfg_ready), 32'd0);
      check("midrst busy", 32'(busy), 32'd1);
      check("midrst done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_sel = '1;
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk); #1;
        if (done) done_cnt++;
        if (c == 1) check("midrst init reg_rst", 32'(reg_rst_o), 32'hFF);
        if (c == 2) check("midrst idle ready", 32'(cfg_ready), 32'd1);
      end
      check("midrst no done", 32'(done_cnt), 32'd0);
      run_req(8'h01, 8'h00, 1'b0, 8'hFE, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
